// File: rtl/gray_sw_pkg.sv
// Shared types and helpers for the DIP-switch Gray-code conditioner.
package gray_sw_pkg;

    typedef enum logic {STABLE = 1'b0, SETTLING = 1'b1} deb_state_t;

    localparam int DEBOUNCE_DEFAULT = 270000;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a vector of independent asynchronous levels.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= d;
            sync2_reg <= sync1_reg;
        end
    end

    assign q = sync2_reg;

endmodule

// File: rtl/gray_switch_conditioner.sv
// Synchronizes and debounces a raw DIP-switch Gray vector as one unit, then
// commits each stable code and flags commits that are not single-bit steps.
module gray_switch_conditioner
    import gray_sw_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             err_clear,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_valid,
    output logic             step_error
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync2;

    deb_state_t       state_reg, state_next;
    logic [WIDTH-1:0] cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             first_done_reg, first_done_next;
    logic [WIDTH-1:0] gray_reg, gray_next;
    logic             valid_reg, valid_next;
    logic             err_reg, err_next;
    logic             commit;
    logic             step_bad;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_in),
        .q     (sync2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= STABLE;
            cand_reg       <= '0;
            cnt_reg        <= '0;
            first_done_reg <= 1'b0;
            gray_reg       <= '0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cand_reg       <= cand_next;
            cnt_reg        <= cnt_next;
            first_done_reg <= first_done_next;
            gray_reg       <= gray_next;
            valid_reg      <= valid_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cand_next       = cand_reg;
        cnt_next        = cnt_reg;
        first_done_next = first_done_reg;
        gray_next       = gray_reg;
        valid_next      = 1'b0;
        commit          = 1'b0;

        case (state_reg)
            STABLE: begin
                if (sync2 != gray_reg) begin
                    cand_next  = sync2;
                    cnt_next   = '0;
                    state_next = SETTLING;
                end
            end
            SETTLING: begin
                // Bounce beats everything: any movement restarts the window.
                if (sync2 != cand_reg) begin
                    cand_next = sync2;
                    cnt_next  = '0;
                end else if (cand_reg == gray_reg) begin
                    state_next = STABLE;
                end else if (cnt_reg == CNT_LAST) begin
                    commit          = 1'b1;
                    gray_next       = cand_reg;
                    valid_next      = 1'b1;
                    first_done_next = 1'b1;
                    state_next      = STABLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = STABLE;
        endcase
    end

    // The first commit after reset is exempt: power-on setting vs reset value 0.
    always_comb begin
        step_bad = first_done_reg && (popcount(32'(cand_reg ^ gray_reg)) != 1);
        err_next = err_reg;
        if (commit && step_bad) begin
            err_next = 1'b1;
        end else if (err_clear) begin
            err_next = 1'b0;
        end
    end

    assign gray_out   = gray_reg;
    assign gray_valid = valid_reg;
    assign step_error = err_reg;

endmodule

// File: tb/tb_gray_switch_conditioner.sv
// Randomized scoreboard bench: a window-based reference model predicts commits,
// a negedge monitor compares every cycle and pops one entry per gray_valid pulse.
module tb_gray_switch_conditioner;

    localparam int W = 4;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] g;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic         err_clear = 1'b0;
    logic [W-1:0] gray_out;
    logic         gray_valid;
    logic         step_error;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: sync2 = raw switches two edges late; commit when
    // the last D+1 sampled sync2 values agree and differ from the output.
    logic [W-1:0] m_s1, m_s2, m_gout, m_samp;
    logic         m_valid, m_err, m_first, m_set, m_same;
    logic [W-1:0] win[$];
    exp_t         sb[$];

    gray_switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .err_clear  (err_clear),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .step_error (step_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_gout = '0;
            m_valid = 1'b0; m_err = 1'b0; m_first = 1'b0;
            win.delete();
            sb.delete();
        end else begin
            m_samp = m_s2;
            m_s2 = m_s1;
            m_s1 = sw_in;
            win.push_back(m_samp);
            if (win.size() > D + 1) void'(win.pop_front());
            m_valid = 1'b0;
            m_set = 1'b0;
            if (win.size() == D + 1) begin
                m_same = 1'b1;
                foreach (win[i]) if (win[i] != win[0]) m_same = 1'b0;
                if (m_same && win[0] != m_gout) begin
                    m_set   = m_first && ($countones(win[0] ^ m_gout) != 1);
                    m_gout  = win[0];
                    m_first = 1'b1;
                    m_valid = 1'b1;
                end
            end
            if (m_set) m_err = 1'b1;
            else if (err_clear) m_err = 1'b0;
            if (m_valid) sb.push_back('{g: m_gout, e: m_err});
        end
    end

    // Monitor: per-cycle state check plus a scoreboard pop on every pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gray_out", gray_out, m_gout);
            check("step_error", W'(step_error), W'(m_err));
            check("gray_valid", W'(gray_valid), W'(m_valid));
            if (gray_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse at %0t: got gray_out=%b expected no pulse", $time, gray_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("commit_code", gray_out, e.g);
                    check("commit_err", W'(step_error), W'(e.e));
                end
            end
        end
    end

    task automatic hold(input logic [W-1:0] v, input int n, input bit rand_clr);
        sw_in = v;
        for (int i = 0; i < n; i++) begin
            err_clear = rand_clr && ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        err_clear = 1'b0;
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_gray_out", gray_out, '0);
        check("rst_gray_valid", W'(gray_valid), '0);
        check("rst_step_error", W'(step_error), '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_gray_out", gray_out, '0);
        check("reset_step_error", W'(step_error), '0);
        rst_n = 1'b1;

        hold(4'b0000, 20, 1'b0);
        hold(4'b0011, 12, 1'b0);
        hold(4'b0010, 12, 1'b0);
        hold(4'b0110, 2, 1'b0);
        hold(4'b0010, 2, 1'b0);
        hold(4'b0110, 12, 1'b0);
        hold(4'b0111, 2, 1'b0);
        hold(4'b0110, 12, 1'b0);
        hold(4'b0101, 12, 1'b0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        hold(4'b0101, 3, 1'b0);
        hold(4'b0100, 4, 1'b0);
        mid_reset();
        hold(4'b0100, 12, 1'b0);

        for (int s = 0; s < 400; s++) begin
            v = sw_in;
            case ($urandom_range(0, 3))
                0: v = W'($urandom);
                1, 2: v[$urandom_range(0, W - 1)] ^= 1'b1;
                default: ;
            endcase
            hold(v, $urandom_range(1, 3 * D), 1'b1);
            if ($urandom_range(0, 49) == 0) mid_reset();
        end
        hold(sw_in, 12, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
